// File: rtl/score_pkg.sv
// Shared types and widths for the match score keeper.
package score_pkg;

    localparam int unsigned SCORE_W   = 7;
    localparam int unsigned SCORE_MAX = 127;
    localparam int unsigned LOCK_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

endpackage

// File: rtl/score_keeper_point_counter.sv
// Per-player saturating point counter with synchronous clear and a registered
// flag that is high while the count equals the win threshold.
module point_counter
    import score_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    input  logic [SCORE_W-1:0] win,
    output logic [SCORE_W-1:0] count,
    output logic               at_win
);

    logic [SCORE_W-1:0] count_next_c;

    // Clear wins over increment; the count never wraps past SCORE_MAX.
    always_comb begin
        count_next_c = count;
        if (clr) begin
            count_next_c = '0;
        end else if (inc && (count != SCORE_W'(SCORE_MAX))) begin
            count_next_c = count + SCORE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            at_win <= 1'b0;
        end else begin
            count  <= count_next_c;
            at_win <= (count_next_c == win);
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Match score keeper: IDLE/PLAY/OVER state machine over two point counters.
// Optional post-point lockout window is enabled with SCORE_LOCKOUT_EN.
module score_keeper
    import score_pkg::*;
#(
    parameter int unsigned WIN_SCORE      = 10,
    parameter int unsigned LOCKOUT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               my_hit,
    input  logic               op_hit,
    output logic [SCORE_W-1:0] my_score,
    output logic [SCORE_W-1:0] op_score,
    output logic               playing,
    output logic               game_over
);

    localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] WIN_M1  = SCORE_W'(WIN_SCORE - 1);

    if (WIN_SCORE < 1 || WIN_SCORE > SCORE_MAX) begin : g_bad_win
        $error("score_keeper: WIN_SCORE out of range");
    end
    if (LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 255) begin : g_bad_lockout
        $error("score_keeper: LOCKOUT_CYCLES out of range");
    end

    state_t state;
    state_t state_next;
    logic   clr_c;
    logic   accept_c;
    logic   my_inc_c;
    logic   op_inc_c;
    logic   lock_free_c;
    logic   my_at_win;
    logic   op_at_win;

`ifdef SCORE_LOCKOUT_EN
    logic [LOCK_W-1:0] lock_cnt;

    assign lock_free_c = (lock_cnt == '0);

    // Lockout window: reloaded on an accepted point, cleared whenever PLAY is left or restarted.
    always_ff @(posedge clk) begin
        if (rst || start || (state_next != PLAY)) begin
            lock_cnt <= '0;
        end else if (accept_c) begin
            lock_cnt <= LOCK_W'(LOCKOUT_CYCLES);
        end else if (lock_cnt != '0) begin
            lock_cnt <= lock_cnt - LOCK_W'(1);
        end
    end
`else
    assign lock_free_c = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            playing   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_next;
            playing   <= (state_next == PLAY);
            game_over <= (state_next == OVER);
        end
    end

    // Start has priority in every state and drops same-cycle hits.
    always_comb begin
        state_next = state;
        clr_c      = 1'b0;
        accept_c   = 1'b0;
        my_inc_c   = 1'b0;
        op_inc_c   = 1'b0;
        if (start) begin
            state_next = PLAY;
            clr_c      = 1'b1;
        end else if (state == PLAY) begin
            accept_c = (my_hit || op_hit) && lock_free_c && !(my_at_win || op_at_win);
            my_inc_c = accept_c && my_hit;
            op_inc_c = accept_c && op_hit;
            if ((my_inc_c && (my_score == WIN_M1)) || (op_inc_c && (op_score == WIN_M1))) begin
                state_next = OVER;
            end
        end
    end

    point_counter u_my (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_c),
        .inc    (my_inc_c),
        .win    (WIN),
        .count  (my_score),
        .at_win (my_at_win)
    );

    point_counter u_op (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_c),
        .inc    (op_inc_c),
        .win    (WIN),
        .count  (op_score),
        .at_win (op_at_win)
    );

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed match scenarios plus random pulses against a behavioural match model.
module tb_score_keeper;

    localparam int unsigned WIN  = 10;
    localparam int unsigned LOCK = 4;
`ifdef SCORE_LOCKOUT_EN
    localparam int LOCK_LEN = LOCK;
`else
    localparam int LOCK_LEN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       my_hit = 1'b0;
    logic       op_hit = 1'b0;
    logic [6:0] my_score;
    logic [6:0] op_score;
    logic       playing;
    logic       game_over;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;

    // Model: mode 0 idle, 1 playing, 2 over.
    int m_mode = 0;
    int m_my   = 0;
    int m_op   = 0;
    int m_lock = 0;

    score_keeper #(.WIN_SCORE(WIN), .LOCKOUT_CYCLES(LOCK)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .my_hit    (my_hit),
        .op_hit    (op_hit),
        .my_score  (my_score),
        .op_score  (op_score),
        .playing   (playing),
        .game_over (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_step(input bit r, input bit s, input bit m, input bit o);
        if (r) begin
            m_mode = 0; m_my = 0; m_op = 0; m_lock = 0;
        end else if (s) begin
            m_mode = 1; m_my = 0; m_op = 0; m_lock = 0;
        end else if (m_mode == 1) begin
            if ((m || o) && m_lock == 0) begin
                if (m) m_my = (m_my + 1 > 127) ? 127 : m_my + 1;
                if (o) m_op = (m_op + 1 > 127) ? 127 : m_op + 1;
                m_lock = LOCK_LEN;
                if (m_my == int'(WIN) || m_op == int'(WIN)) begin
                    m_mode = 2;
                    m_lock = 0;
                end
            end else if (m_lock > 0) begin
                m_lock--;
            end
        end
    endfunction

    // Every cycle, compare all outputs against the model.
    always @(negedge clk) begin
        if (armed) begin
            chk("my_score", int'(my_score), m_my);
            chk("op_score", int'(op_score), m_op);
            chk("playing", int'(playing), int'(m_mode == 1));
            chk("game_over", int'(game_over), int'(m_mode == 2));
        end
    end

    task automatic cyc(input bit r, input bit s, input bit m, input bit o);
        rst = r; start = s; my_hit = m; op_hit = o;
        @(posedge clk);
        model_step(r, s, m, o);
        armed = 1'b1;
        #1;
    endtask

    task automatic gap();
        repeat (6) cyc(0, 0, 0, 0);
    endtask

    task automatic points(input int nm, input int no);
        for (int i = 0; i < nm; i++) begin cyc(0, 0, 1, 0); gap(); end
        for (int i = 0; i < no; i++) begin cyc(0, 0, 0, 1); gap(); end
    endtask

    initial begin
        // Reset, then hits in IDLE are ignored.
        repeat (3) cyc(1, 0, 0, 0);
        chk("reset_my", int'(my_score), 0);
        chk("reset_playing", int'(playing), 0);
        chk("reset_over", int'(game_over), 0);
        repeat (3) cyc(0, 0, 1, 0);
        chk("idle_my", int'(my_score), 0);
        chk("idle_playing", int'(playing), 0);

        // Basic scoring with one-cycle latency.
        cyc(0, 1, 0, 0);
        chk("start_playing", int'(playing), 1);
        cyc(0, 0, 1, 0);
        chk("first_hit_latency", int'(my_score), 1);
        gap();
        points(2, 2);
        chk("basic_my", int'(my_score), 3);
        chk("basic_op", int'(op_score), 2);

        // Win at 10, then frozen.
        cyc(0, 1, 0, 0);
        points(9, 0);
        chk("pre_win_over", int'(game_over), 0);
        cyc(0, 0, 1, 0);
        chk("win_my", int'(my_score), 10);
        chk("win_over", int'(game_over), 1);
        chk("win_playing", int'(playing), 0);
        points(3, 2);
        chk("frozen_my", int'(my_score), 10);
        chk("frozen_op", int'(op_score), 0);

        // Tie at 10/10 from 9/9.
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin cyc(0, 0, 1, 1); gap(); end
        chk("tie_my", int'(my_score), 10);
        chk("tie_op", int'(op_score), 10);
        chk("tie_over", int'(game_over), 1);

        // Start with a hit drops the hit.
        cyc(0, 1, 1, 1);
        chk("start_hit_my", int'(my_score), 0);
        chk("start_hit_playing", int'(playing), 1);
        chk("start_hit_over", int'(game_over), 0);

        // Restart and reset mid-match at 5/3.
        points(5, 3);
        chk("mid_my", int'(my_score), 5);
        cyc(0, 1, 0, 0);
        chk("restart_my", int'(my_score), 0);
        chk("restart_op", int'(op_score), 0);
        points(5, 3);
        cyc(1, 0, 0, 0);
        chk("rst_mid_my", int'(my_score), 0);
        chk("rst_mid_playing", int'(playing), 0);
        cyc(0, 0, 0, 0);

`ifdef SCORE_LOCKOUT_EN
        // Held hit: accepted on cycles 0 and 5 only.
        cyc(0, 1, 0, 0);
        repeat (6) cyc(0, 0, 1, 0);
        chk("lockout_held", int'(my_score), 2);
        cyc(0, 0, 0, 0);
`endif

        // Random pulses, occasional restarts and resets.
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 59) == 0),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
        end

        armed = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
